// File: rtl/cmp_search_pkg.sv
// Shared constants for the comparator-driven search family: default operand
// width, probe counter width and the search FSM state encoding.
package cmp_search_pkg;

  localparam int CMP_WIDTH = 4;
  localparam int PROBE_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/cmp_search_mid.sv
// Midpoint of an inclusive [lo, hi] window; operands carry one guard bit so
// the sum cannot wrap.
module cmp_mid
  import cmp_search_pkg::*;
#(
  parameter int WIDTH = CMP_WIDTH
) (
  input  logic [WIDTH:0]   lo_i,
  input  logic [WIDTH:0]   hi_i,
  output logic [WIDTH-1:0] mid_o
);

  logic [WIDTH:0] sum;

  assign sum   = lo_i + hi_i;
  assign mid_o = WIDTH'(sum >> 1);

endmodule

// File: rtl/cmp_search.sv
// Binary search of an unknown target driven by an external gt/eq/lt
// comparator that sees the registered guess.
//
// state  | meaning
// IDLE   | waiting for start after reset
// SEARCH | probing: one comparator response consumed per cycle
// DONE   | result/err/probes held until the next start
module cmp_search
  import cmp_search_pkg::*;
#(
  parameter int WIDTH = CMP_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               gt,
  input  logic               eq,
  input  logic               lt,
  output logic [WIDTH-1:0]   guess,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result,
  output logic               err,
  output logic [PROBE_W-1:0] probes
);

  localparam logic [WIDTH:0] HI_INIT = (WIDTH+1)'((1 << WIDTH) - 1);
  localparam logic [WIDTH:0] ONE     = (WIDTH+1)'(1);

  state_e               state_q;
  logic [WIDTH:0]       lo_q, hi_q;
  logic [WIDTH-1:0]     guess_q, result_q;
  logic [PROBE_W-1:0]   probes_q;
  logic                 err_q, busy_q, done_q;

  logic [WIDTH:0]       guess_ext, lo_d, hi_d;
  logic [WIDTH-1:0]     mid;
  logic                 resp_ok;

  assign guess_ext = {1'b0, guess_q};
  assign resp_ok   = $onehot({gt, eq, lt});

  // Outside SEARCH the window is the full range, so the same midpoint unit
  // provides the first guess on start.
  always_comb begin
    lo_d = '0;
    hi_d = HI_INIT;
    if (state_q == ST_SEARCH) begin
      if (gt) begin
        lo_d = guess_ext + ONE;
        hi_d = hi_q;
      end else begin
        lo_d = lo_q;
        hi_d = guess_ext - ONE;
      end
    end
  end

  cmp_mid #(.WIDTH(WIDTH)) u_mid (
    .lo_i  (lo_d),
    .hi_i  (hi_d),
    .mid_o (mid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      lo_q     <= '0;
      hi_q     <= '0;
      guess_q  <= '0;
      result_q <= '0;
      probes_q <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q  <= ST_SEARCH;
            lo_q     <= '0;
            hi_q     <= HI_INIT;
            guess_q  <= mid;
            probes_q <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
          end
        end
        ST_SEARCH: begin
          probes_q <= probes_q + PROBE_W'(1);
          if (!resp_ok || (gt && guess_ext == hi_q) || (lt && guess_ext == lo_q)) begin
            state_q <= ST_DONE;
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (eq) begin
            state_q  <= ST_DONE;
            result_q <= guess_q;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end else begin
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            guess_q <= mid;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign guess  = guess_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign err    = err_q;
  assign probes = probes_q;

endmodule

// File: tb/tb_cmp_search.sv
// Bench for cmp_search: behavioural comparator plus an integer binary-search
// reference that predicts the probe sequence and final outputs.
module tb_cmp_search;
  import cmp_search_pkg::*;

  localparam int W    = CMP_WIDTH;
  localparam int MAXV = (1 << W) - 1;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               start = 1'b0;
  logic               gt, eq, lt;
  logic [W-1:0]       guess, result;
  logic               busy, done, err;
  logic [PROBE_W-1:0] probes;

  // 0: honest comparator, 1: always gt, 2: always lt, 3: gt+eq, 4: silent
  int mode = 0;
  int tgt  = 0;

  int n_cmp  = 0;
  int n_fail = 0;

  int exp_g[$];
  bit exp_err;
  int exp_res;
  int last_res = 0;

  always #5 clk = ~clk;

  always_comb begin
    gt = 1'b0;
    eq = 1'b0;
    lt = 1'b0;
    case (mode)
      0: begin
        gt = (tgt > int'(guess));
        eq = (tgt == int'(guess));
        lt = (tgt < int'(guess));
      end
      1: gt = 1'b1;
      2: lt = 1'b1;
      3: begin gt = 1'b1; eq = 1'b1; end
      default: ;
    endcase
  end

  cmp_search #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .gt     (gt),
    .eq     (eq),
    .lt     (lt),
    .guess  (guess),
    .busy   (busy),
    .done   (done),
    .result (result),
    .err    (err),
    .probes (probes)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Plain integer binary search over [0, MAXV] with the given responder.
  task automatic model(input int m, input int t);
    int lo, hi, g;
    exp_g.delete();
    exp_err = 1'b0;
    exp_res = last_res;
    lo = 0;
    hi = MAXV;
    for (int k = 0; k < 2 * W + 4; k++) begin
      g = (lo + hi) / 2;
      exp_g.push_back(g);
      if (m == 3 || m == 4) begin exp_err = 1'b1; break; end
      if (m == 0 && t == g) begin exp_res = g; break; end
      if (m == 1 || (m == 0 && t > g)) begin
        if (g == hi) begin exp_err = 1'b1; break; end
        lo = g + 1;
      end else begin
        if (g == lo) begin exp_err = 1'b1; break; end
        hi = g - 1;
      end
    end
    last_res = exp_res;
  endtask

  task automatic launch(input int m, input int t, input bit hold);
    mode = m;
    tgt  = t;
    model(m, t);
    start = 1'b1;
    tick();
    if (!hold) start = 1'b0;
  endtask

  task automatic probe_and_finish(input string tag);
    for (int k = 0; k < exp_g.size(); k++) begin
      check($sformatf("%s busy%0d", tag, k), busy, 1);
      check($sformatf("%s guess%0d", tag, k), guess, exp_g[k]);
      tick();
    end
    check({tag, " done"}, done, 1);
    check({tag, " busy_end"}, busy, 0);
    check({tag, " err"}, err, exp_err);
    check({tag, " result"}, result, exp_res);
    check({tag, " probes"}, probes, exp_g.size());
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " guess"}, guess, 0);
    check({tag, " result"}, result, 0);
    check({tag, " probes"}, probes, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
    check({tag, " err"}, err, 0);
  endtask

  initial begin
    int m, t, gap;

    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    tick();
    tick();
    #2 rst_n = 1'b1;
    tick();
    check("idle done", done, 0);

    launch(0, 7, 1'b0);
    probe_and_finish("t7");
    repeat (3) tick();
    check("hold done", done, 1);
    check("hold result", result, 7);
    check("hold probes", probes, 1);
    check("hold err", err, 0);

    launch(0, 0, 1'b0);
    probe_and_finish("t0");
    launch(0, 15, 1'b0);
    probe_and_finish("t15");

    launch(3, 0, 1'b0);
    probe_and_finish("gt_eq");
    launch(1, 0, 1'b0);
    probe_and_finish("exh_gt");
    launch(2, 0, 1'b0);
    probe_and_finish("exh_lt");
    launch(4, 0, 1'b0);
    probe_and_finish("silent");

    // Abort mid-search after two probes.
    launch(0, 15, 1'b0);
    tick();
    tick();
    check("pre_abort guess", guess, 13);
    check("pre_abort busy", busy, 1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("abort");
    last_res = 0;
    #1 rst_n = 1'b1;
    launch(0, 4, 1'b0);
    probe_and_finish("t4");

    // start held through a whole search restarts only from DONE.
    t = $urandom_range(0, MAXV);
    launch(0, t, 1'b1);
    probe_and_finish("held");
    tick();
    check("restart busy", busy, 1);
    check("restart done", done, 0);
    check("restart probes", probes, 0);
    check("restart guess", guess, MAXV / 2);
    start = 1'b0;
    model(0, t);
    probe_and_finish("held2");

    for (int i = 0; i < 24; i++) begin
      m   = ($urandom_range(0, 9) < 7) ? 0 : int'($urandom_range(1, 4));
      t   = $urandom_range(0, MAXV);
      gap = $urandom_range(0, 3);
      repeat (gap) tick();
      launch(m, t, 1'b0);
      probe_and_finish($sformatf("rnd%0d m%0d t%0d", i, m, t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cmp_search.md
CMP_SEARCH -- requirements
Module: cmp_search

Interface
REQ-001 Parameter: WIDTH, default 4, operand width of the probe bus and result.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request a new search; sampled only in IDLE or DONE.
REQ-005 gt  input  1  external comparator: target greater than guess.
REQ-006 eq  input  1  external comparator: target equal to guess.
REQ-007 lt  input  1  external comparator: target less than guess.
REQ-008 guess  output  WIDTH  registered probe value driven to the comparator B side.
REQ-009 busy  output  1  high while in SEARCH.
REQ-010 done  output  1  high while in DONE.
REQ-011 result  output  WIDTH  value found; valid when done=1 and err=0.
REQ-012 err  output  1  search failed; valid when done=1.
REQ-013 probes  output  3  number of comparisons consumed by the last search (max WIDTH+1).

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, SEARCH, DONE.
REQ-015 IDLE or DONE with start=1 -> SEARCH; bounds lo=0, hi=2^WIDTH-1; guess=(lo+hi)>>1; probes=0; err=0.
REQ-016 In SEARCH, gt/eq/lt SHALL be sampled every cycle against the current registered guess (combinational comparator, zero-latency response).
REQ-017 eq only: result<=guess, probes+1, -> DONE, err=0.
REQ-018 gt only: lo<=guess+1, guess<=(guess+1+hi)>>1, probes+1, stay SEARCH.
REQ-019 lt only: hi<=guess-1, guess<=(lo+guess-1)>>1, probes+1, stay SEARCH.
REQ-020 Bound arithmetic SHALL use WIDTH+1 bits; sums SHALL NOT wrap.
REQ-021 gt with guess==hi, or lt with guess==lo (exhausted range) -> DONE, err=1, result unchanged.
REQ-022 Any response other than exactly one of gt/eq/lt high -> DONE, err=1.
REQ-023 start while in SEARCH SHALL be ignored.
REQ-024 DONE SHALL hold result, err, probes, done until the next accepted start.
REQ-025 A consistent comparator SHALL yield done within WIDTH+1 cycles of entering SEARCH.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, guess=0, result=0, probes=0, busy=0, done=0, err=0.
REQ-027 Reset asserted mid-search SHALL abort it; no partial result is retained.
REQ-028 Deassertion SHALL take effect at the next clk edge; the first start is accepted no earlier than that edge.

Structure
REQ-029 State encodings and the default WIDTH SHALL live in a shared constants file used by all comparator-family blocks.
REQ-030 The block SHALL be a single module; next-guess midpoint logic MAY be one sub-module named cmp_mid.
REQ-031 The comparator is external; the bench SHALL connect a cmp instance of matching WIDTH (target on A, guess on B).

Verification
REQ-032 target=7, start pulse -> first guess=7, eq; done next cycle, result=7, probes=1, err=0.
REQ-033 target=0 -> guesses 7,3,1,0; result=0, probes=4, err=0.
REQ-034 target=15 -> guesses 7,11,13,14,15; result=15, probes=5, err=0.
REQ-035 Forced gt and eq both high on first probe -> DONE, err=1, probes=1.
REQ-036 target=15, rst_n low after 2 probes -> IDLE, all outputs 0; new start with target=4 -> guesses 7,3,5,4, result=4, probes=4.
REQ-037 start held high throughout a search -> no restart in SEARCH; new search begins on the cycle after entering DONE.
